// File: rtl/pim_peri_pkg.sv
// rtl/pim_peri_pkg.sv - shared types, defaults and width helper for the PIM peripheral
package pim_peri_pkg;

    localparam int OUT_W_DEF = 1024;
    localparam int BUS_W_DEF = 32;

    typedef enum logic {
        RD_SEQ  = 1'b0,
        RD_RAND = 1'b1
    } rd_mode_e;

    // Index width that never collapses to zero bits for tiny ranges.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pim_output_fifo_if.sv
// rtl/pim_output_fifo_if.sv - capture/read/flush bundle between array, controller and output FIFO
interface pim_output_fifo_if
    import pim_peri_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int BUS_W = BUS_W_DEF,
    parameter int DEPTH = 4
);
    localparam int WORDS  = OUT_W / BUS_W;
    localparam int WIDX_W = idx_width(WORDS);
    localparam int CNT_W  = idx_width(DEPTH + 1);

    logic [OUT_W-1:0]  output_i;
    logic              capture_i;
    logic              rd_en_i;
    rd_mode_e          rd_mode_i;
    logic [WIDX_W-1:0] word_idx_i;
    logic              pop_i;
    logic              clear_i;
    logic [BUS_W-1:0]  data_o;
    logic              data_valid_o;
    logic [CNT_W-1:0]  count_o;
    logic              empty_o;
    logic              full_o;
    logic [WIDX_W-1:0] word_ptr_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output output_i, capture_i, rd_en_i, rd_mode_i, word_idx_i, pop_i, clear_i,
        input  data_o, data_valid_o, count_o, empty_o, full_o, word_ptr_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  output_i, capture_i, rd_en_i, rd_mode_i, word_idx_i, pop_i, clear_i,
        output data_o, data_valid_o, count_o, empty_o, full_o, word_ptr_o,
               overflow_o, underflow_o
    );

endinterface

// File: rtl/pim_output_fifo_slice_mux.sv
// rtl/pim_output_fifo_slice_mux.sv - selects one BUS_W slice out of a full-width output vector
module pim_slice_mux
    import pim_peri_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int BUS_W = BUS_W_DEF,
    localparam int WORDS  = OUT_W / BUS_W,
    localparam int WIDX_W = idx_width(WORDS)
) (
    input  logic [OUT_W-1:0]  i_vec,
    input  logic [WIDX_W-1:0] i_idx,
    output logic [BUS_W-1:0]  o_slice
);

    always_comb begin
        o_slice = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (i_idx == WIDX_W'(k)) begin
                o_slice = i_vec[k*BUS_W +: BUS_W];
            end
        end
    end

endmodule

// File: rtl/pim_output_fifo.sv
// rtl/pim_output_fifo.sv - DEPTH-entry FIFO of array output vectors served as bus slices
module pim_output_fifo
    import pim_peri_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int BUS_W = BUS_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pim_output_fifo_if.slave   bus
);

    localparam int WORDS  = OUT_W / BUS_W;
    localparam int WIDX_W = idx_width(WORDS);
    localparam int PTR_W  = idx_width(DEPTH);
    localparam int CNT_W  = idx_width(DEPTH + 1);

    logic [OUT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic [WIDX_W-1:0] r_word_ptr;
    logic              r_overflow;
    logic              r_underflow;
    logic [BUS_W-1:0]  r_data;
    logic              r_data_valid;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_seq;
    logic              w_last_word;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_underflow;
    logic [WIDX_W-1:0] w_rd_idx;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [BUS_W-1:0]  w_slice;

    // A pop in the same cycle frees the slot a capture into a full FIFO needs.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CNT_W'(DEPTH));
        w_rd_seq    = bus.rd_en_i && (bus.rd_mode_i == RD_SEQ) && !w_empty;
        w_last_word = (r_word_ptr == WIDX_W'(WORDS - 1));
        w_pop       = !w_empty && (bus.pop_i || (w_rd_seq && w_last_word));
        w_push      = bus.capture_i && (!w_full || w_pop);
        w_drop      = bus.capture_i && w_full && !w_pop;
        w_underflow = (bus.rd_en_i || bus.pop_i) && w_empty;
        w_rd_idx    = (bus.rd_mode_i == RD_RAND) ? bus.word_idx_i : r_word_ptr;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    pim_slice_mux #(
        .OUT_W (OUT_W),
        .BUS_W (BUS_W)
    ) u_slice_mux (
        .i_vec   (r_mem[r_head]),
        .i_idx   (w_rd_idx),
        .o_slice (w_slice)
    );

    always_ff @(posedge clk_i) begin
        if (w_push && !bus.clear_i) begin
            r_mem[r_tail] <= bus.output_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || bus.clear_i) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_word_ptr   <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            if (w_pop) begin
                r_word_ptr <= '0;
            end else if (w_rd_seq) begin
                r_word_ptr <= r_word_ptr + WIDX_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end
            r_data_valid <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                r_data <= w_empty ? '0 : w_slice;
            end
        end
    end

    assign bus.data_o       = r_data;
    assign bus.data_valid_o = r_data_valid;
    assign bus.count_o      = r_count;
    assign bus.empty_o      = r_empty;
    assign bus.full_o       = r_full;
    assign bus.word_ptr_o   = r_word_ptr;
    assign bus.overflow_o   = r_overflow;
    assign bus.underflow_o  = r_underflow;

endmodule

// File: tb/tb_pim_output_fifo.sv
// tb/tb_pim_output_fifo.sv - directed and randomized bench with a queue-based reference model
module tb_pim_output_fifo;
    import pim_peri_pkg::*;

    localparam int OUT_W = 1024;
    localparam int BUS_W = 32;
    localparam int DEPTH = 4;
    localparam int WORDS = OUT_W / BUS_W;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pim_output_fifo_if #(.OUT_W(OUT_W), .BUS_W(BUS_W), .DEPTH(DEPTH)) bus ();

    pim_output_fifo #(.OUT_W(OUT_W), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole vectors plus a slice pointer and flags.
    logic [OUT_W-1:0] m_q[$];
    int               m_wp = 0;
    bit               m_ovf = 0, m_unf = 0, m_dv = 0;
    logic [BUS_W-1:0] m_data = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || bus.clear_i) begin
            m_q.delete();
            m_wp = 0; m_ovf = 0; m_unf = 0; m_dv = 0; m_data = '0;
        end else begin
            int n0;
            bit was_empty, seq_last, do_pop;
            logic [OUT_W-1:0] head;
            int idx;
            n0 = m_q.size();
            was_empty = (n0 == 0);
            m_dv = bus.rd_en_i;
            seq_last = 0;
            if (bus.rd_en_i) begin
                if (was_empty) begin
                    m_data = '0;
                    m_unf = 1;
                end else begin
                    head = m_q[0];
                    idx = (bus.rd_mode_i == RD_RAND) ? int'(bus.word_idx_i) : m_wp;
                    m_data = head[idx*BUS_W +: BUS_W];
                    if (bus.rd_mode_i == RD_SEQ) begin
                        seq_last = (m_wp == WORDS - 1);
                        m_wp = seq_last ? 0 : m_wp + 1;
                    end
                end
            end
            if (bus.pop_i && was_empty) m_unf = 1;
            do_pop = !was_empty && (bus.pop_i || seq_last);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_wp = 0;
            end
            if (bus.capture_i) begin
                if (n0 == DEPTH && !do_pop) m_ovf = 1;
                else m_q.push_back(bus.output_i);
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("count_o", 64'(bus.count_o), 64'(m_q.size()));
            chk("empty_o", 64'(bus.empty_o), 64'(m_q.size() == 0));
            chk("full_o", 64'(bus.full_o), 64'(m_q.size() == DEPTH));
            chk("word_ptr_o", 64'(bus.word_ptr_o), 64'(m_wp));
            chk("overflow_o", 64'(bus.overflow_o), 64'(m_ovf));
            chk("underflow_o", 64'(bus.underflow_o), 64'(m_unf));
            chk("data_valid_o", 64'(bus.data_valid_o), 64'(m_dv));
            chk("data_o", 64'(bus.data_o), 64'(m_data));
        end
    end

    task automatic idle();
        bus.capture_i  = 1'b0;
        bus.rd_en_i    = 1'b0;
        bus.rd_mode_i  = RD_SEQ;
        bus.word_idx_i = '0;
        bus.pop_i      = 1'b0;
        bus.clear_i    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] mkvec(input logic [31:0] base);
        logic [OUT_W-1:0] v;
        for (int k = 0; k < WORDS; k++) v[k*BUS_W +: BUS_W] = base + 32'(k);
        return v;
    endfunction

    task automatic cap(input logic [31:0] base);
        idle(); bus.capture_i = 1'b1; bus.output_i = mkvec(base); tick(); idle();
    endtask

    task automatic rd_seq();
        idle(); bus.rd_en_i = 1'b1; tick(); idle();
    endtask

    task automatic rd_rand(input int idx);
        idle(); bus.rd_en_i = 1'b1; bus.rd_mode_i = RD_RAND; bus.word_idx_i = 5'(idx); tick(); idle();
    endtask

    task automatic do_clear();
        idle(); bus.clear_i = 1'b1; tick(); idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, 64'(bus.count_o), 64'd0);
        chk({tag, " empty"}, 64'(bus.empty_o), 64'd1);
        chk({tag, " full"}, 64'(bus.full_o), 64'd0);
        chk({tag, " wptr"}, 64'(bus.word_ptr_o), 64'd0);
        chk({tag, " data"}, 64'(bus.data_o), 64'd0);
        chk({tag, " dvalid"}, 64'(bus.data_valid_o), 64'd0);
        chk({tag, " ovf"}, 64'(bus.overflow_o), 64'd0);
        chk({tag, " unf"}, 64'(bus.underflow_o), 64'd0);
    endtask

    logic [31:0] exp_base [4];

    initial begin
        idle();
        bus.output_i = '0;
        #2 rst_i = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        chk_on = 1'b1;

        // Two captures, then one full sequential pass over the head entry.
        cap(32'h1000_0000);
        cap(32'h1000_0000);
        chk("two caps count", 64'(bus.count_o), 64'd2);
        chk("two caps empty", 64'(bus.empty_o), 64'd0);
        for (int k = 0; k < WORDS; k++) begin
            rd_seq();
            chk("seq data", 64'(bus.data_o), 64'(32'h1000_0000 + k));
            chk("seq valid", 64'(bus.data_valid_o), 64'd1);
        end
        chk("after pass count", 64'(bus.count_o), 64'd1);
        chk("after pass wptr", 64'(bus.word_ptr_o), 64'd0);
        tick();
        chk("valid drops", 64'(bus.data_valid_o), 64'd0);

        // Overflow: fifth capture is dropped.
        do_clear();
        for (int e = 0; e < DEPTH; e++) cap(32'h1000_0000 * (e + 1));
        cap(32'h5000_0000);
        chk("ovf full", 64'(bus.full_o), 64'd1);
        chk("ovf flag", 64'(bus.overflow_o), 64'd1);
        chk("ovf count", 64'(bus.count_o), 64'd4);
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < WORDS; k++) begin
                rd_seq();
                chk("ovf drain", 64'(bus.data_o), 64'(32'h1000_0000 * (e + 1) + k));
            end
        end
        chk("ovf drained", 64'(bus.empty_o), 64'd1);

        // Full FIFO accepts a capture on the cycle the head auto-pops.
        do_clear();
        for (int e = 0; e < DEPTH; e++) cap(32'h1000_0000 * (e + 1));
        for (int k = 0; k < WORDS - 1; k++) rd_seq();
        idle(); bus.rd_en_i = 1'b1; bus.capture_i = 1'b1; bus.output_i = mkvec(32'h6000_0000);
        tick(); idle();
        chk("swap count", 64'(bus.count_o), 64'd4);
        chk("swap full", 64'(bus.full_o), 64'd1);
        chk("swap ovf", 64'(bus.overflow_o), 64'd0);
        chk("swap data", 64'(bus.data_o), 64'h1000_001F);
        exp_base = '{32'h2000_0000, 32'h3000_0000, 32'h4000_0000, 32'h6000_0000};
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < WORDS; k++) begin
                rd_seq();
                chk("swap drain", 64'(bus.data_o), 64'(exp_base[e] + k));
            end
        end

        // Random access leaves head and pointer alone.
        do_clear();
        cap(32'h1000_0000);
        cap(32'h2000_0000);
        rd_rand(31); chk("rand 31", 64'(bus.data_o), 64'h1000_001F);
        rd_rand(0);  chk("rand 0", 64'(bus.data_o), 64'h1000_0000);
        rd_rand(7);  chk("rand 7", 64'(bus.data_o), 64'h1000_0007);
        chk("rand count", 64'(bus.count_o), 64'd2);
        chk("rand wptr", 64'(bus.word_ptr_o), 64'd0);
        idle(); bus.pop_i = 1'b1; tick(); idle();
        chk("pop count", 64'(bus.count_o), 64'd1);
        rd_rand(3);  chk("rand next", 64'(bus.data_o), 64'h2000_0003);

        // Empty boundaries.
        do_clear();
        rd_seq();
        chk("empty rd data", 64'(bus.data_o), 64'd0);
        chk("empty rd valid", 64'(bus.data_valid_o), 64'd1);
        chk("empty rd unf", 64'(bus.underflow_o), 64'd1);
        do_clear();
        idle(); bus.pop_i = 1'b1; tick(); idle();
        chk("empty pop count", 64'(bus.count_o), 64'd0);
        chk("empty pop unf", 64'(bus.underflow_o), 64'd1);
        do_clear();
        idle(); bus.pop_i = 1'b1; bus.capture_i = 1'b1; bus.output_i = mkvec(32'h7000_0000);
        tick(); idle();
        chk("cap+pop count", 64'(bus.count_o), 64'd1);
        chk("cap+pop unf", 64'(bus.underflow_o), 64'd1);

        // Flush in the middle of a sequential pass, with a capture that must be dropped.
        do_clear();
        cap(32'h1000_0000);
        for (int k = 0; k < 10; k++) rd_seq();
        chk("pre-flush wptr", 64'(bus.word_ptr_o), 64'd10);
        idle(); bus.clear_i = 1'b1; bus.rd_en_i = 1'b1; bus.capture_i = 1'b1;
        bus.output_i = mkvec(32'h8000_0000);
        tick(); idle();
        chk_reset_vals("flush");

        // Randomized traffic: capture-heavy first half, drain-heavy second half.
        for (int c = 0; c < 3000; c++) begin
            idle();
            bus.clear_i   = ($urandom_range(0, 63) == 0);
            bus.capture_i = ($urandom_range(0, 9) < ((c < 1500) ? 4 : 1));
            for (int w = 0; w < WORDS; w++) bus.output_i[w*BUS_W +: BUS_W] = $urandom();
            bus.rd_en_i    = 1'($urandom_range(0, 1));
            bus.rd_mode_i  = ($urandom_range(0, 3) == 0) ? RD_RAND : RD_SEQ;
            bus.word_idx_i = 5'($urandom_range(0, WORDS - 1));
            bus.pop_i      = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();

        // Asynchronous reset between clock edges.
        cap(32'h9000_0000);
        rd_seq();
        rd_seq();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1 chk_reset_vals("async rst");
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pim_output_fifo.md
Name: pim_output_fifo

Overview:
- Parametrised successor of the single-entry output buffer in the PIM peripheral.
- Captures full-width sense/ADC output vectors from the eFLASH array into a DEPTH-entry FIFO.
- Serves them to the RISC-V data port as BUS_W-bit slices, in either sequential (auto-increment, auto-pop) or random-access mode.
- Sits between eFLASH_driver (capture strobe), the PIM macro (output vector) and peri_controller (read/pop/flush).

Parameters:
- OUT_W, 1024: width of one array output vector; must be a multiple of BUS_W.
- BUS_W, 32: bus slice width.
- DEPTH, 4: number of stored vectors; power of two, at least 2.
- WORDS (localparam): OUT_W/BUS_W, the number of slices per entry.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- output_i  in  OUT_W  array output vector.
- capture_i  in  1  one-cycle strobe: push output_i at the tail.
- rd_en_i  in  1  read one slice of the head entry.
- rd_mode_i  in  1  0 = RD_SEQ, 1 = RD_RAND.
- word_idx_i  in  clog2(WORDS)  slice index used in RD_RAND.
- pop_i  in  1  discard the head entry.
- clear_i  in  1  synchronous flush.
- data_o  out  BUS_W  registered read data.
- data_valid_o  out  1  qualifies data_o, one cycle.
- count_o  out  clog2(DEPTH+1)  number of occupied entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- word_ptr_o  out  clog2(WORDS)  sequential slice pointer.
- overflow_o  out  1  sticky: a capture was dropped.
- underflow_o  out  1  sticky: a read or pop was attempted while empty.

Behaviour:
- Reset (async, rst_i=1): head, tail, count and word_ptr are 0.
  - data_o=0, data_valid_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
  - Storage contents are not reset.
- Slice k of an entry is bits [k*BUS_W +: BUS_W].
- Priority each cycle: clear_i, then pop/auto-pop, then capture, then read data return.
- clear_i=1:
  - head, tail, count, word_ptr, both sticky flags, data_o and data_valid_o go to 0.
  - A simultaneous capture, read or pop is ignored.
- Capture (capture_i=1, clear_i=0):
  - Writes output_i to entry tail; tail advances modulo DEPTH; count increments.
  - If full and no pop happens in the same cycle: the capture is dropped, overflow_o is set, and no state changes.
  - If full and a pop/auto-pop happens in the same cycle: the capture is accepted and count is unchanged.
- Read (rd_en_i=1):
  - One-cycle latency: data_o and data_valid_o=1 update on the next edge.
  - RD_SEQ: returns slice word_ptr of head; word_ptr increments. When word_ptr==WORDS-1 it wraps to 0 and the head is auto-popped in the same cycle.
  - RD_RAND: returns slice word_idx_i of head; word_ptr and head are unchanged.
  - Read while empty: data_o=0, data_valid_o=1, underflow_o set, no pointer change.
  - A simultaneous capture into an empty FIFO is not visible to the same-cycle read.
- data_valid_o is 0 in any cycle not following a read. data_o holds its last value otherwise.
- pop_i:
  - Advances head, decrements count and resets word_ptr to 0.
  - Pop while empty sets underflow_o. Capture + pop while empty: capture accepted, pop ignored, underflow_o set.
  - pop_i combined with an RD_SEQ auto-pop in the same cycle pops exactly once.
- Changing rd_mode_i mid-entry does not reset word_ptr.
- count_o, empty_o and full_o are registered and reflect state after the edge.
- Sticky flags clear only on clear_i or reset.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous reset).

Decomposition:
- Package pim_peri_pkg holds:
  - OUT_W_DEF=1024 and BUS_W_DEF=32.
  - typedef enum logic {RD_SEQ=1'b0, RD_RAND=1'b1} rd_mode_e.
  - A clog2-based width helper.
- One natural sub-module: pim_slice_mux (parametrised OUT_W/BUS_W combinational slice select). Storage and control stay in pim_output_fifo.

Test Plan:
- Reset state: reset, then 2 captures of vector V0 (slice k = 32'h1000_0000+k) → count_o=2, empty_o=0. Then 32 RD_SEQ reads → data_o = 32'h1000_0000..32'h1000_001F with one-cycle latency, count_o=1 after the 32nd read, word_ptr_o=0.
- Overflow: fill 4 entries, 5th capture → full_o=1, overflow_o=1, count_o=4. Then RD_SEQ reads drain V0..V3 in order and the dropped vector never appears.
- Full with simultaneous event: when full, capture on the same cycle as the 32nd RD_SEQ read → accepted, count_o stays 4, the new vector is read last.
- Random access: RD_RAND reads with word_idx_i=31, 0, 7 → the matching slices are returned, head and count unchanged. Then pop_i → count decrements and the next entry is served.
- Empty boundaries: read when empty → data_o=0, data_valid_o=1, underflow_o=1. pop when empty → count stays 0. Capture+pop on empty → count_o=1, underflow_o=1.
- Flush and reset: clear_i during a sequential read at word 10 → all pointers 0, flags 0, simultaneous capture dropped. rst_i mid-stream → outputs at reset values before the next clock edge.
